// File: rtl/loongarch_pkg.sv
// Shared LoongArch decode constants: opcode field groups, default widths and
// the source-2 selection encoding used by the ID operand stage.
package loongarch_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;

  // op_31_26 group
  localparam logic [5:0] OP6_ALU       = 6'h00;
  localparam logic [5:0] OP6_LU12I     = 6'h05;
  localparam logic [5:0] OP6_PCADDU12I = 6'h07;
  localparam logic [5:0] OP6_MEM       = 6'h0a;
  localparam logic [5:0] OP6_B         = 6'h14;
  localparam logic [5:0] OP6_BL        = 6'h15;
  localparam logic [5:0] OP6_BEQ       = 6'h16;
  localparam logic [5:0] OP6_BNE       = 6'h17;
  localparam logic [5:0] OP6_BLT       = 6'h18;
  localparam logic [5:0] OP6_BGE       = 6'h19;
  localparam logic [5:0] OP6_BLTU      = 6'h1a;
  localparam logic [5:0] OP6_BGEU      = 6'h1b;

  // op_25_22 group
  localparam logic [3:0] OP4_ALU  = 4'h0;
  localparam logic [3:0] OP4_ST_B = 4'h4;
  localparam logic [3:0] OP4_ST_H = 4'h5;
  localparam logic [3:0] OP4_ST_W = 4'h6;

  // op_21_20 group
  localparam logic [1:0] OP2_3R  = 2'b01;
  localparam logic [1:0] OP2_DIV = 2'b10;

  // op_19_15 group
  localparam logic [4:0] OP5_ADD    = 5'h00;
  localparam logic [4:0] OP5_SUB    = 5'h02;
  localparam logic [4:0] OP5_SLT    = 5'h04;
  localparam logic [4:0] OP5_SLTU   = 5'h05;
  localparam logic [4:0] OP5_NOR    = 5'h08;
  localparam logic [4:0] OP5_AND    = 5'h09;
  localparam logic [4:0] OP5_OR     = 5'h0a;
  localparam logic [4:0] OP5_XOR    = 5'h0b;
  localparam logic [4:0] OP5_SLL    = 5'h0e;
  localparam logic [4:0] OP5_SRL    = 5'h0f;
  localparam logic [4:0] OP5_SRA    = 5'h10;
  localparam logic [4:0] OP5_MUL    = 5'h18;
  localparam logic [4:0] OP5_MULH   = 5'h19;
  localparam logic [4:0] OP5_MULHU  = 5'h1a;

  typedef enum logic [1:0] {
    SRC2_NONE = 2'd0,
    SRC2_RK   = 2'd1,
    SRC2_RD   = 2'd2
  } src2_sel_e;

  // True for register-register ALU, multiply and divide forms
  function automatic logic is_3r(input logic [1:0] op2, input logic [4:0] op5);
    logic r;
    case (op2)
      OP2_3R: begin
        case (op5)
          OP5_ADD, OP5_SUB, OP5_SLT, OP5_SLTU, OP5_NOR, OP5_AND, OP5_OR,
          OP5_XOR, OP5_SLL, OP5_SRL, OP5_SRA, OP5_MUL, OP5_MULH, OP5_MULHU: r = 1'b1;
          default: r = 1'b0;
        endcase
      end
      OP2_DIV: r = (op5[4:2] == 3'b000);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_src_decode.sv
// Combinational source-register decode: which of rj/rk/rd an instruction reads.
module id_src_decode
  import loongarch_pkg::*;
#(
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic [31:0]        inst,
  output logic               src1_used,
  output logic [RADDR_W-1:0] src1,
  output logic               src2_used,
  output logic [RADDR_W-1:0] src2
);

  logic [5:0] op6_s;
  logic [3:0] op4_s;
  logic [1:0] op2_s;
  logic [4:0] op5_s;
  logic       no_src1_s;
  src2_sel_e  src2_sel_s;

  assign op6_s = inst[31:26];
  assign op4_s = inst[25:22];
  assign op2_s = inst[21:20];
  assign op5_s = inst[19:15];

  // lu12i.w / pcaddu12i share their major opcode with other forms; bit 25 separates them
  assign no_src1_s = (op6_s == OP6_B) || (op6_s == OP6_BL) ||
                     (((op6_s == OP6_LU12I) || (op6_s == OP6_PCADDU12I)) && !op4_s[3]);

  // Source-2 selection by instruction class
  always_comb begin
    src2_sel_s = SRC2_NONE;
    case (op6_s)
      OP6_BEQ, OP6_BNE, OP6_BLT, OP6_BGE, OP6_BLTU, OP6_BGEU: src2_sel_s = SRC2_RD;
      OP6_MEM: begin
        if ((op4_s == OP4_ST_B) || (op4_s == OP4_ST_H) || (op4_s == OP4_ST_W)) begin
          src2_sel_s = SRC2_RD;
        end else begin
          src2_sel_s = SRC2_NONE;
        end
      end
      OP6_ALU: begin
        if ((op4_s == OP4_ALU) && is_3r(op2_s, op5_s)) begin
          src2_sel_s = SRC2_RK;
        end else begin
          src2_sel_s = SRC2_NONE;
        end
      end
      default: src2_sel_s = SRC2_NONE;
    endcase
  end

  // Index outputs; unused sources read register 0
  always_comb begin
    src1_used = !no_src1_s;
    src1      = no_src1_s ? '0 : RADDR_W'(inst[9:5]);
    src2_used = 1'b0;
    src2      = '0;
    case (src2_sel_s)
      SRC2_RK: begin
        src2_used = 1'b1;
        src2      = RADDR_W'(inst[14:10]);
      end
      SRC2_RD: begin
        src2_used = 1'b1;
        src2      = RADDR_W'(inst[4:0]);
      end
      default: begin
        src2_used = 1'b0;
        src2      = '0;
      end
    endcase
  end

endmodule

// File: rtl/id_operand_stage.sv
// ID stage: IF->ID register, operand bypass from EX/ME/WB, hazard stall and
// a saturating stall-cycle counter.
module id_operand_stage
  import loongarch_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter bit FWD_EN  = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               if_valid,
  input  logic [XLEN-1:0]    if_pc,
  input  logic [31:0]        if_inst,
  output logic               id_allowin,
  input  logic               flush,
  input  logic               ex_allowin,
  output logic               id_to_ex_valid,
  output logic [XLEN-1:0]    id_pc,
  output logic [31:0]        id_inst,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  input  logic               ex_valid,
  input  logic               ex_we,
  input  logic               ex_ready,
  input  logic [RADDR_W-1:0] ex_dest,
  input  logic [XLEN-1:0]    ex_data,
  input  logic               me_valid,
  input  logic               me_we,
  input  logic               me_ready,
  input  logic [RADDR_W-1:0] me_dest,
  input  logic [XLEN-1:0]    me_data,
  input  logic               wb_valid,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_dest,
  input  logic [XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]    src1_value,
  output logic [XLEN-1:0]    src2_value,
  output logic               stall,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic               id_valid_r;
  logic [XLEN-1:0]    id_pc_r;
  logic [31:0]        id_inst_r;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic               src1_used_s;
  logic               src2_used_s;
  logic [RADDR_W-1:0] src1_s;
  logic [RADDR_W-1:0] src2_s;
  logic [RADDR_W-1:0] src_idx_s [2];
  logic               src_used_s [2];
  logic [XLEN-1:0]    rf_data_s [2];
  logic [XLEN-1:0]    src_val_s [2];
  logic               hazard_s [2];
  logic               ready_go_s;

  id_src_decode #(.RADDR_W(RADDR_W)) u_src_decode (
    .inst      (id_inst_r),
    .src1_used (src1_used_s),
    .src1      (src1_s),
    .src2_used (src2_used_s),
    .src2      (src2_s)
  );

  assign src_idx_s[0]  = src1_s;
  assign src_idx_s[1]  = src2_s;
  assign src_used_s[0] = src1_used_s;
  assign src_used_s[1] = src2_used_s;
  assign rf_data_s[0]  = rf_rdata1;
  assign rf_data_s[1]  = rf_rdata2;

  // Per-source operand resolution, EX > ME > WB > RF, recomputed every cycle
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      logic ex_m, me_m, wb_m, haz;
      ex_m = ex_valid & ex_we & (ex_dest == src_idx_s[i]) & (src_idx_s[i] != '0);
      me_m = me_valid & me_we & (me_dest == src_idx_s[i]) & (src_idx_s[i] != '0);
      wb_m = wb_valid & wb_we & (wb_dest == src_idx_s[i]) & (src_idx_s[i] != '0);
      src_val_s[i] = rf_data_s[i];
      haz          = 1'b0;
      if (src_idx_s[i] == '0) begin
        src_val_s[i] = '0;
        haz          = 1'b0;
      end else if (FWD_EN) begin
        if (ex_m) begin
          src_val_s[i] = ex_data;
          haz          = !ex_ready;
        end else if (me_m) begin
          src_val_s[i] = me_data;
          haz          = !me_ready;
        end else if (wb_m) begin
          src_val_s[i] = wb_data;
          haz          = 1'b0;
        end else begin
          src_val_s[i] = rf_data_s[i];
          haz          = 1'b0;
        end
      end else begin
        src_val_s[i] = rf_data_s[i];
        haz          = ex_m | me_m | wb_m;
      end
      hazard_s[i] = haz & src_used_s[i];
    end
  end

  assign stall          = id_valid_r & (hazard_s[0] | hazard_s[1]);
  assign ready_go_s     = !stall;
  assign id_allowin     = !id_valid_r | (ready_go_s & ex_allowin);
  assign id_to_ex_valid = id_valid_r & ready_go_s & !flush;
  assign rf_raddr1      = src1_s;
  assign rf_raddr2      = src2_s;
  assign src1_value     = src_val_s[0];
  assign src2_value     = src_val_s[1];
  assign id_pc          = id_pc_r;
  assign id_inst        = id_inst_r;
  assign stall_cnt      = stall_cnt_r;

  // Valid flag: flush wins over an incoming instruction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_valid_r <= 1'b0;
    end else if (flush) begin
      id_valid_r <= 1'b0;
    end else if (id_allowin) begin
      id_valid_r <= if_valid;
    end
  end

  // PC and instruction capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_pc_r   <= '0;
      id_inst_r <= 32'h0000_0000;
    end else if (if_valid && id_allowin && !flush) begin
      id_pc_r   <= if_pc;
      id_inst_r <= if_inst;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_r <= '0;
    end else if (stall && (stall_cnt_r != '1)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: forwarding, interlock mode and counter
// saturation, with three parameterisations sharing one stimulus stream.
module tb_id_operand_stage;

  localparam logic [31:0] ADD_R6_R5_R7 = 32'h0010_1CA6;
  localparam logic [31:0] BEQ_R4_R0    = 32'h5800_0080;
  localparam logic [31:0] ADD_R1_R3_R3 = 32'h0010_0C61;
  localparam logic [31:0] ADD_R1_R0_R0 = 32'h0010_0001;
  localparam logic [31:0] LU12I_R1     = 32'h1400_00A1;

  logic        clk, resetn, if_valid, flush, ex_allowin;
  logic [31:0] if_pc, if_inst;
  logic        ex_valid, ex_we, ex_ready, me_valid, me_we, me_ready, wb_valid, wb_we;
  logic [4:0]  ex_dest, me_dest, wb_dest;
  logic [31:0] ex_data, me_data, wb_data;

  logic        allowin_a, i2e_a, stall_a, allowin_b, i2e_b, stall_b, allowin_c, i2e_c, stall_c;
  logic [31:0] pc_a, inst_a, s1_a, s2_a, rd1_a, rd2_a, cnt_a;
  logic [31:0] pc_b, inst_b, s1_b, s2_b, rd1_b, rd2_b, cnt_b;
  logic [31:0] pc_c, inst_c, s1_c, s2_c, rd1_c, rd2_c;
  logic [3:0]  cnt_c;
  logic [4:0]  ra1_a, ra2_a, ra1_b, ra2_b, ra1_c, ra2_c;

  int errors = 0;
  int checks = 0;

  // Register-file model: data encodes the address read
  assign rd1_a = 32'hAA00_0000 | {27'd0, ra1_a};
  assign rd2_a = 32'hBB00_0000 | {27'd0, ra2_a};
  assign rd1_b = 32'hAA00_0000 | {27'd0, ra1_b};
  assign rd2_b = 32'hBB00_0000 | {27'd0, ra2_b};
  assign rd1_c = 32'hAA00_0000 | {27'd0, ra1_c};
  assign rd2_c = 32'hBB00_0000 | {27'd0, ra2_c};

  id_operand_stage #(.FWD_EN(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .resetn(resetn), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .id_allowin(allowin_a), .flush(flush), .ex_allowin(ex_allowin), .id_to_ex_valid(i2e_a),
    .id_pc(pc_a), .id_inst(inst_a), .rf_raddr1(ra1_a), .rf_raddr2(ra2_a),
    .rf_rdata1(rd1_a), .rf_rdata2(rd2_a),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_ready(ex_ready), .ex_dest(ex_dest), .ex_data(ex_data),
    .me_valid(me_valid), .me_we(me_we), .me_ready(me_ready), .me_dest(me_dest), .me_data(me_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .src1_value(s1_a), .src2_value(s2_a), .stall(stall_a), .stall_cnt(cnt_a));

  id_operand_stage #(.FWD_EN(1'b0), .CNT_W(32)) dut_b (
    .clk(clk), .resetn(resetn), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .id_allowin(allowin_b), .flush(flush), .ex_allowin(ex_allowin), .id_to_ex_valid(i2e_b),
    .id_pc(pc_b), .id_inst(inst_b), .rf_raddr1(ra1_b), .rf_raddr2(ra2_b),
    .rf_rdata1(rd1_b), .rf_rdata2(rd2_b),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_ready(ex_ready), .ex_dest(ex_dest), .ex_data(ex_data),
    .me_valid(me_valid), .me_we(me_we), .me_ready(me_ready), .me_dest(me_dest), .me_data(me_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .src1_value(s1_b), .src2_value(s2_b), .stall(stall_b), .stall_cnt(cnt_b));

  id_operand_stage #(.FWD_EN(1'b1), .CNT_W(4)) dut_c (
    .clk(clk), .resetn(resetn), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .id_allowin(allowin_c), .flush(flush), .ex_allowin(ex_allowin), .id_to_ex_valid(i2e_c),
    .id_pc(pc_c), .id_inst(inst_c), .rf_raddr1(ra1_c), .rf_raddr2(ra2_c),
    .rf_rdata1(rd1_c), .rf_rdata2(rd2_c),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_ready(ex_ready), .ex_dest(ex_dest), .ex_data(ex_data),
    .me_valid(me_valid), .me_we(me_we), .me_ready(me_ready), .me_dest(me_dest), .me_data(me_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .src1_value(s1_c), .src2_value(s2_c), .stall(stall_c), .stall_cnt(cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] inst);
    if_valid = 1'b1; if_pc = pc; if_inst = inst;
    tick();
    if_valid = 1'b0;
  endtask

  task automatic clr_prod();
    ex_valid = 1'b0; me_valid = 1'b0; wb_valid = 1'b0;
  endtask

  task automatic set_ex(input logic [4:0] d, input logic rdy, input logic [31:0] v);
    ex_valid = 1'b1; ex_we = 1'b1; ex_dest = d; ex_ready = rdy; ex_data = v;
  endtask

  task automatic set_me(input logic [4:0] d, input logic rdy, input logic [31:0] v);
    me_valid = 1'b1; me_we = 1'b1; me_dest = d; me_ready = rdy; me_data = v;
  endtask

  task automatic set_wb(input logic [4:0] d, input logic [31:0] v);
    wb_valid = 1'b1; wb_we = 1'b1; wb_dest = d; wb_data = v;
  endtask

  initial begin
    resetn = 1'b0; if_valid = 1'b0; if_pc = 32'd0; if_inst = 32'd0; flush = 1'b0; ex_allowin = 1'b1;
    ex_valid = 1'b0; ex_we = 1'b0; ex_ready = 1'b0; ex_dest = 5'd0; ex_data = 32'd0;
    me_valid = 1'b0; me_we = 1'b0; me_ready = 1'b0; me_dest = 5'd0; me_data = 32'd0;
    wb_valid = 1'b0; wb_we = 1'b0; wb_dest = 5'd0; wb_data = 32'd0;
    repeat (2) tick();
    check("rst_i2e", i2e_a, 1'b0);
    check("rst_pc", pc_a, 32'd0);
    check("rst_inst", inst_a, 32'd0);
    check("rst_cnt", cnt_a, 32'd0);
    check("rst_allowin", allowin_a, 1'b1);
    resetn = 1'b1;
    tick();

    // EX forward, no bubble
    load(32'h100, ADD_R6_R5_R7);
    set_ex(5'd5, 1'b1, 32'h1234);
    #1;
    check("fwd_pc", pc_a, 32'h100);
    check("fwd_inst", inst_a, ADD_R6_R5_R7);
    check("fwd_raddr2", ra2_a, 5'd7);
    check("fwd_src1", s1_a, 32'h1234);
    check("fwd_src2_rf", s2_a, 32'hBB00_0007);
    check("fwd_stall", stall_a, 1'b0);
    check("fwd_i2e", i2e_a, 1'b1);
    tick();
    clr_prod();
    #1;
    check("fwd_issued", i2e_a, 1'b0);

    // Load-use: one stall cycle, then ME supplies the value
    load(32'h104, BEQ_R4_R0);
    set_ex(5'd4, 1'b0, 32'h0);
    #1;
    check("lu_stall", stall_a, 1'b1);
    check("lu_allowin", allowin_a, 1'b0);
    check("lu_i2e", i2e_a, 1'b0);
    tick();
    ex_valid = 1'b0;
    set_me(5'd4, 1'b1, 32'hdead);
    #1;
    check("lu_stall_after", stall_a, 1'b0);
    check("lu_cnt", cnt_a, 32'd1);
    check("lu_src1", s1_a, 32'hdead);
    check("lu_src2_r0", s2_a, 32'd0);
    check("lu_i2e_after", i2e_a, 1'b1);
    tick();
    clr_prod();

    // Priority EX > ME > WB
    load(32'h108, ADD_R1_R3_R3);
    set_ex(5'd3, 1'b1, 32'hA);
    set_me(5'd3, 1'b0, 32'hC);
    set_wb(5'd3, 32'hB);
    #1;
    check("pri_src1_ex", s1_a, 32'hA);
    check("pri_src2_ex", s2_a, 32'hA);
    check("pri_stall_ex", stall_a, 1'b0);
    ex_valid = 1'b0;
    #1;
    check("pri_stall_me", stall_a, 1'b1);
    me_valid = 1'b0;
    #1;
    check("pri_src1_wb", s1_a, 32'hB);
    check("pri_stall_wb", stall_a, 1'b0);
    tick();
    clr_prod();

    // r0 is never forwarded and never stalls
    load(32'h10C, ADD_R1_R0_R0);
    set_ex(5'd0, 1'b0, 32'h77);
    #1;
    check("r0_src1", s1_a, 32'd0);
    check("r0_stall", stall_a, 1'b0);
    tick();
    clr_prod();

    // Unused source field matching a not-ready producer
    load(32'h110, LU12I_R1);
    set_ex(5'd5, 1'b0, 32'h0);
    #1;
    check("unused_stall", stall_a, 1'b0);
    check("unused_i2e", i2e_a, 1'b1);
    tick();
    clr_prod();

    // Backpressure holds state without counting
    load(32'h114, ADD_R6_R5_R7);
    ex_allowin = 1'b0;
    if_valid = 1'b1; if_pc = 32'h200; if_inst = 32'd0;
    #1;
    check("bp_allowin", allowin_a, 1'b0);
    check("bp_stall", stall_a, 1'b0);
    tick();
    check("bp_pc_hold", pc_a, 32'h114);
    check("bp_cnt", cnt_a, 32'd1);
    ex_allowin = 1'b1; if_valid = 1'b0;

    // Flush during a stall
    set_ex(5'd5, 1'b0, 32'h0);
    flush = 1'b1;
    #1;
    check("fl_stall", stall_a, 1'b1);
    check("fl_i2e", i2e_a, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_stall_drop", stall_a, 1'b0);
    check("fl_cnt", cnt_a, 32'd2);
    clr_prod();

    // Interlock mode: stall until the producer leaves every stage
    resetn = 1'b0; #1; resetn = 1'b1;
    tick();
    load(32'h300, ADD_R6_R5_R7);
    set_ex(5'd5, 1'b1, 32'h1234);
    #1;
    check("il_stall_ex", stall_b, 1'b1);
    check("il_allowin", allowin_b, 1'b0);
    check("il_fwd_ref", s1_a, 32'h1234);
    tick();
    ex_valid = 1'b0;
    set_me(5'd5, 1'b1, 32'h1234);
    #1;
    check("il_stall_me", stall_b, 1'b1);
    tick();
    me_valid = 1'b0;
    set_wb(5'd5, 32'h1234);
    #1;
    check("il_stall_wb", stall_b, 1'b1);
    tick();
    wb_valid = 1'b0;
    #1;
    check("il_stall_done", stall_b, 1'b0);
    check("il_src1_rf", s1_b, 32'hAA00_0005);
    check("il_i2e", i2e_b, 1'b1);
    check("il_cnt", cnt_b, 32'd3);
    tick();

    // Flush beats a simultaneous if_valid
    load(32'h400, ADD_R6_R5_R7);
    if_valid = 1'b1; if_pc = 32'h404; if_inst = ADD_R1_R0_R0; flush = 1'b1;
    tick();
    if_valid = 1'b0; flush = 1'b0;
    set_ex(5'd5, 1'b1, 32'h0);
    #1;
    check("fi_pc_hold", pc_b, 32'h400);
    check("fi_inst_hold", inst_b, ADD_R6_R5_R7);
    check("fi_no_stall", stall_b, 1'b0);
    check("fi_i2e", i2e_b, 1'b0);
    clr_prod();

    // Counter saturation on the 4-bit instance
    resetn = 1'b0; #1; resetn = 1'b1;
    tick();
    load(32'h500, ADD_R6_R5_R7);
    set_ex(5'd5, 1'b0, 32'h0);
    repeat (14) tick();
    check("sat_cnt14", cnt_c, 4'hE);
    repeat (6) tick();
    check("sat_cnt20", cnt_c, 4'hF);
    check("wide_cnt20", cnt_a, 32'd20);
    check("pre_rst_stall", stall_a, 1'b1);

    // Asynchronous reset mid-stream
    resetn = 1'b0;
    #1;
    check("arst_stall", stall_a, 1'b0);
    check("arst_i2e", i2e_a, 1'b0);
    check("arst_cnt", cnt_a, 32'd0);
    check("arst_pc", pc_a, 32'd0);
    check("arst_cnt4", cnt_c, 4'h0);
    clr_prod();
    resetn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised successor ID stage for the LoongArch in-order pipeline. It holds the IF→ID pipeline register and decodes which source registers each instruction reads.
- It resolves both source operands from the EX/ME/WB bypass network or the register file. It stalls only on true not-yet-available hazards: load-use, multi-cycle producers, or any match when forwarding is disabled.
- It sits between the IF stage and the full control decoder/EX stage. It also exposes a saturating stall-cycle performance counter.

Parameters:
- XLEN, 32, datapath and PC width.
- RADDR_W, 5, register index width (register 0 hard-wired to zero).
- FWD_EN, 1, 1 = bypass from EX/ME/WB; 0 = stall on any pending match (legacy interlock mode).
- CNT_W, 32, stall performance counter width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- if_valid  in  1  IF has an instruction
- if_pc  in  XLEN  fetched PC
- if_inst  in  32  fetched instruction
- id_allowin  out  1  ID can accept this cycle
- flush  in  1  branch/exception redirect; kill the ID contents
- ex_allowin  in  1  EX accepts this cycle
- id_to_ex_valid  out  1  ID issues this cycle
- id_pc  out  XLEN  registered PC
- id_inst  out  32  registered instruction (to the control decoder)
- rf_raddr1, rf_raddr2  out  RADDR_W  register-file read addresses
- rf_rdata1, rf_rdata2  in  XLEN  register-file read data
- ex_valid, ex_we, ex_ready  in  1 each  EX producer valid, writes a register, result available this cycle
- ex_dest  in  RADDR_W  EX destination
- ex_data  in  XLEN  EX result
- me_valid, me_we, me_ready, me_dest, me_data  in  as EX  ME producer
- wb_valid, wb_we, wb_dest, wb_data  in  as EX  WB producer (always ready)
- src1_value, src2_value  out  XLEN  resolved operands
- stall  out  1  ID valid but blocked by a hazard
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, resetn=0):
  - id_valid=0, id_pc=0, id_inst=0, stall_cnt=0.
  - All outputs derived from id_valid are deasserted immediately, including mid-operation.
- Handshake:
  - id_allowin = !id_valid | (ready_go & ex_allowin); ready_go = !stall.
  - id_to_ex_valid = id_valid & ready_go & !flush.
- Valid register update, by priority:
  - flush → id_valid=0.
  - else if id_allowin → id_valid=if_valid.
  - Flush beats a simultaneous if_valid; the instruction is dropped.
- PC/inst register: loads when if_valid & id_allowin & !flush; otherwise holds.
- Source decode (sub-module):
  - src1 = rj, used unless b, bl, lu12i.w or pcaddu12i.
  - src2 = rd for beq/bne/blt/bge/bltu/bgeu and stores; rk for 3R ALU/mul/div; unused otherwise.
  - rf_raddr2 is driven by the selected src2 index.
- Per-source resolution (combinational, priority EX > ME > WB > RF):
  - A producer matches when stage_valid & stage_we & dest==src & src!=0.
  - src==0 → value 0; never forwarded, never stalls.
  - Unused sources never stall.
- Hazard rules:
  - FWD_EN=1: stall iff the highest-priority matching producer has ready=0. WB is always ready.
  - FWD_EN=0: stall iff any stage matches; values always come from the RF.
  - stall = id_valid & (hazard1 | hazard2).
  - Operands are recomputed every cycle while stalled; nothing is latched.
- Backpressure: when !ex_allowin and no hazard, hold state; stall=0 and the counter does not increment.
- stall_cnt: +1 on each cycle with stall=1, saturating at all-ones, no wrap. Cleared only by reset.
- Flush during a stall: id_valid clears next edge, so stall drops the following cycle.

Decomposition:
- Shared package (loongarch_pkg):
  - Opcode field constants for the op_31_26, op_25_22, op_21_20 and op_19_15 groups.
  - RADDR_W and XLEN defaults.
  - The src-usage encoding (SRC2_NONE/RK/RD).
- One sub-module, id_src_decode: purely combinational inst → {src1_used, src1, src2_used, src2}.

Test Plan:
- Reset: drive resetn=0 mid-stream with id_valid=1 → id_valid, id_to_ex_valid, stall and stall_cnt read 0 before the next edge.
- EX forward: add.w r5 issued to EX with ex_ready=1, ex_data=0x1234; ID holds add.w r6,r5,r7 → src1_value=0x1234, stall=0, no bubble.
- Load-use: ld.w r4 in EX (ex_ready=0); ID holds beq r4,r0 → stall=1 for exactly one cycle, id_allowin=0, stall_cnt=1. Next cycle, ME supplies 0xdead with me_ready=1 → src1_value=0xdead, issue.
- Priority and r0: EX and WB both write r3 (0xA, 0xB) → src value 0xA. Instruction reading r0 while EX writes r0 → value 0, no stall.
- FWD_EN=0: same EX match as the EX forward case → stall until WB retires r5 and it leaves all stages, then value comes from rf_rdata1. flush+if_valid in the same cycle → id_valid=0, id_pc unchanged.
- Counter saturation: CNT_W=4 with 20 consecutive stall cycles → stall_cnt=0xF and holds.
